// File: rtl/seven_seg_reader.sv
// Watches a two-digit multiplexed seven-segment bus and filters each digit for stability.
// Decodes the digits back to nibbles and emits the reassembled byte once per completed pair.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no digit held for the current pair
// HAVE_HI | Dig1 nibble held, waiting for Dig2
// HAVE_LO | Dig2 nibble held, waiting for Dig1
// EMIT    | pair complete; Value/Valid loaded on the next edge
module seven_seg_reader #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] seg_bus_i,
    input  logic [1:0] dig_sel_i,
    output logic [7:0] value_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       err_digit_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_HI = 2'd1,
        HAVE_LO = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam logic [3:0] ACC_CNT = 4'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] seg_q;
    logic [1:0] sel_q;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [7:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       err_digit_q, err_digit_d;

    logic       one_hot;
    logic       same;
    logic       accept;
    logic       is_hi;
    logic       dec_ok;
    logic [3:0] dec_nib;

    assign one_hot = (dig_sel_i == 2'b01) || (dig_sel_i == 2'b10);
    assign same    = (seg_bus_i == seg_q) && (dig_sel_i == sel_q);
    assign is_hi   = (dig_sel_i == 2'b10);

    always_comb begin
        cnt_d = 4'd0;
        if (one_hot && same) begin
            cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end
    end

    // A fresh run (!same) or a genuine increment reaching the threshold accepts;
    // sitting saturated at the threshold does not.
    assign accept = one_hot && (cnt_d == ACC_CNT) && (!same || (cnt_d != cnt_q));

    always_comb begin
        dec_ok  = 1'b1;
        dec_nib = 4'h0;
        case (seg_bus_i[6:0])
            7'b0111111: dec_nib = 4'h0;
            7'b0000110: dec_nib = 4'h1;
            7'b1011011: dec_nib = 4'h2;
            7'b1001111: dec_nib = 4'h3;
            7'b1100110: dec_nib = 4'h4;
            7'b1101101: dec_nib = 4'h5;
            7'b1111101: dec_nib = 4'h6;
            7'b0000111: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1101111: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b1111100: dec_nib = 4'hB;
            7'b0111001: dec_nib = 4'hC;
            7'b1011110: dec_nib = 4'hD;
            7'b1111001: dec_nib = 4'hE;
            7'b1110001: dec_nib = 4'hF;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        value_d     = value_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        err_digit_d = err_digit_q;

        if (state_q == EMIT) begin
            value_d = {hi_q, lo_q};
            valid_d = 1'b1;
            state_d = IDLE;
        end

        // Evaluated after EMIT so an acceptance in that cycle starts the next pair.
        if (accept) begin
            if (!dec_ok) begin
                error_d     = 1'b1;
                err_digit_d = is_hi;
            end else if (is_hi) begin
                hi_d = dec_nib;
                case (state_d)
                    IDLE:    state_d = HAVE_HI;
                    HAVE_LO: state_d = EMIT;
                    default: ;
                endcase
            end else begin
                lo_d = dec_nib;
                case (state_d)
                    IDLE:    state_d = HAVE_LO;
                    HAVE_HI: state_d = EMIT;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            seg_q       <= 8'h00;
            sel_q       <= 2'b00;
            cnt_q       <= 4'd0;
            hi_q        <= 4'h0;
            lo_q        <= 4'h0;
            value_q     <= 8'h00;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_digit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_bus_i;
            sel_q       <= dig_sel_i;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign value_o     = value_q;
    assign valid_o     = valid_q;
    assign error_o     = error_q;
    assign err_digit_o = err_digit_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader with STABLE_CYCLES=2.
// A monitor counts Valid/Error cycles; each scenario task checks the deltas.
module tb_seven_seg_reader;

    logic       clk;
    logic       rst_n;
    logic [7:0] seg_bus;
    logic [1:0] dig_sel;
    logic [7:0] value;
    logic       valid;
    logic       error;
    logic       err_digit;

    int checks   = 0;
    int failures = 0;

    int         valid_cnt = 0;
    int         err_cnt   = 0;
    logic [7:0] last_val  = 8'h00;
    logic [7:0] prev_val  = 8'h00;

    seven_seg_reader #(.STABLE_CYCLES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .seg_bus_i   (seg_bus),
        .dig_sel_i   (dig_sel),
        .value_o     (value),
        .valid_o     (valid),
        .error_o     (error),
        .err_digit_o (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (valid) begin
            valid_cnt = valid_cnt + 1;
            prev_val  = last_val;
            last_val  = value;
        end
        if (error) err_cnt = err_cnt + 1;
    end

    task automatic hold(input logic [1:0] sel, input logic [7:0] seg, input int n);
        dig_sel = sel;
        seg_bus = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(2'b00, 8'h00, n);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        dig_sel = 2'b00;
        seg_bus = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL reset_value got=%h exp=00", value); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (err_digit !== 1'b0) begin failures++; $display("FAIL reset_errdigit got=%b exp=0", err_digit); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic_pair;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        hold(2'b10, 8'b01111100, 3);
        hold(2'b01, 8'b01001111, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'hB3) begin failures++; $display("FAIL basic_value got=%h exp=b3", last_val); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL basic_error got=%0d exp=%0d", err_cnt, e0); end
        checks++; if (value !== 8'hB3) begin failures++; $display("FAIL basic_value_hold got=%h exp=b3", value); end
    endtask

    task automatic test_reverse_order;
        int v0;
        v0 = valid_cnt;
        hold(2'b01, 8'b00000110, 3);
        hold(2'b10, 8'b01110001, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL reverse_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'hF1) begin failures++; $display("FAIL reverse_value got=%h exp=f1", last_val); end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = valid_cnt;
        hold(2'b10, 8'b01111100, 3);
        hold(2'b10, 8'b01111111, 1);
        hold(2'b01, 8'b01001111, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL glitch_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'hB3) begin failures++; $display("FAIL glitch_value got=%h exp=b3", last_val); end
    endtask

    task automatic test_invalid;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        hold(2'b01, 8'b00000001, 3);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL invalid_err_count got=%0d exp=1", err_cnt - e0); end
        checks++; if (err_digit !== 1'b0) begin failures++; $display("FAIL invalid_errdigit_lo got=%b exp=0", err_digit); end
        hold(2'b10, 8'b00000110, 3);
        idle(3);
        checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL invalid_no_valid got=%0d exp=%0d", valid_cnt, v0); end
        // dp set on the low digit must be ignored
        hold(2'b01, 8'b10111111, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL invalid_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'h10) begin failures++; $display("FAIL invalid_value got=%h exp=10", last_val); end
        hold(2'b10, 8'b00000000, 3);
        idle(2);
        checks++; if (err_cnt - e0 !== 2) begin failures++; $display("FAIL invalid_err_count2 got=%0d exp=2", err_cnt - e0); end
        checks++; if (err_digit !== 1'b1) begin failures++; $display("FAIL invalid_errdigit_hi got=%b exp=1", err_digit); end
        checks++; if (value !== 8'h10) begin failures++; $display("FAIL invalid_value_hold got=%h exp=10", value); end
    endtask

    task automatic test_overwrite_hold;
        int v0;
        v0 = valid_cnt;
        hold(2'b10, 8'b01001111, 20);
        hold(2'b10, 8'b01110111, 20);
        hold(2'b01, 8'b00111111, 20);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL overwrite_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'hA0) begin failures++; $display("FAIL overwrite_value got=%h exp=a0", last_val); end
        // A re-accepted Dig2 would make this lone Dig1 complete a pair.
        hold(2'b10, 8'b00000110, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL overwrite_no_reaccept got=%0d exp=1", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = valid_cnt;
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        hold(2'b10, 8'b01111100, 2);
        hold(2'b01, 8'b01001111, 2);
        hold(2'b10, 8'b00000110, 2);
        hold(2'b01, 8'b00111111, 2);
        idle(4);
        checks++; if (valid_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=2", valid_cnt - v0); end
        checks++; if (prev_val !== 8'hB3) begin failures++; $display("FAIL b2b_first_value got=%h exp=b3", prev_val); end
        checks++; if (last_val !== 8'h10) begin failures++; $display("FAIL b2b_second_value got=%h exp=10", last_val); end
    endtask

    task automatic test_reset_mid_pair;
        int v0;
        v0 = valid_cnt;
        hold(2'b10, 8'b00000110, 3);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL midreset_value got=%h exp=00", value); end
        hold(2'b01, 8'b01011011, 3);
        idle(4);
        checks++; if (valid_cnt !== v0) begin failures++; $display("FAIL midreset_no_valid got=%0d exp=%0d", valid_cnt, v0); end
        checks++; if (value !== 8'h00) begin failures++; $display("FAIL midreset_value_hold got=%h exp=00", value); end
        // Completing with Dig1 shows the FSM was holding only the low nibble.
        hold(2'b10, 8'b01101101, 3);
        idle(4);
        checks++; if (valid_cnt - v0 !== 1) begin failures++; $display("FAIL midreset_complete_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_val !== 8'h52) begin failures++; $display("FAIL midreset_complete_value got=%h exp=52", last_val); end
    endtask

    initial begin
        rst_n   = 1'b0;
        dig_sel = 2'b00;
        seg_bus = 8'h00;
        @(negedge clk);
        test_reset;
        test_basic_pair;
        test_reverse_order;
        test_glitch;
        test_invalid;
        test_overwrite_hold;
        test_back_to_back;
        test_reset_mid_pair;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
